rle_encoder: RTL and testbench
==============================

RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 SHALL have parameter COMP_NUM, default 3: number of independent DC predictors, addressed by comp_sel values 1..COMP_NUM.
REQ-002 SHALL have port sys_clk, input, 1: clock; all registers update on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port sof, input, 1: start-of-frame pulse; clears the DC predictors and the block index.
REQ-005 SHALL have port data_in, input, 12, signed: zigzag-ordered quantized coefficient.
REQ-006 SHALL have port data_valid, input, 1: data_in is valid this cycle; 64 valid beats form one block.
REQ-007 SHALL have port comp_sel, input, 2: component tag (1=Y, 2=Cb, 3=Cr), sampled on the beat with index 0 only.
REQ-008 SHALL have port sym_valid, output, 1: symbol fields are valid this cycle.
REQ-009 SHALL have port sym_is_dc, output, 1: the symbol is a DC difference.
REQ-010 SHALL have port sym_zrl, output, 2: number of ZRL (16-zero) codes that precede this symbol.
REQ-011 SHALL have port sym_run, output, 4: zero run modulo 16 before this AC symbol; 0 for DC.
REQ-012 SHALL have port sym_size, output, 4: magnitude category (bit length of |value|, 0..12).
REQ-013 SHALL have port sym_amp, output, 12: JPEG amplitude bits, right-aligned, zeros above sym_size.
REQ-014 SHALL have port sym_comp, output, 2: component tag of the block that produced the symbol.
REQ-015 SHALL have port block_done, output, 1: pulse on the last symbol of a block.

Function
REQ-016 SHALL keep a 6-bit index that advances only on data_valid beats and wraps from 63 to 0; idle cycles between beats are legal.
REQ-017 SHALL treat index 0 as DC: diff = data_in - pred[comp_sel], computed with 13-bit signed arithmetic; pred[comp_sel] <= data_in; the symbol always has sym_is_dc=1 and sym_zrl=0, and is emitted even when diff=0 (size 0).
REQ-018 SHALL leave the predictors of the other components unchanged on a DC beat.
REQ-019 SHALL, for indices 1..63, count zeros in a 6-bit run counter; a zero produces no symbol (except per REQ-022).
REQ-020 SHALL, on a nonzero AC value v: emit sym_zrl = run/16, sym_run = run%16, size and amp of v; then clear run.
REQ-021 SHALL encode amplitude as v[size-1:0] if v>0, else (v-1)[size-1:0]; size = 0 iff value = 0.
REQ-022 SHALL, on the index-63 beat, emit EOB (sym_run=0, sym_size=0, sym_zrl=0, sym_is_dc=0) if the value is zero; trailing zeros produce no ZRL codes.
REQ-023 SHALL emit no EOB when the index-63 value is nonzero; that symbol is the last symbol of the block.
REQ-024 SHALL assert block_done with the index-63 symbol (EOB or nonzero), and only then.
REQ-025 SHALL present a symbol exactly 2 clock cycles after the data_valid beat that produced it; at most one symbol per cycle; no backpressure.
REQ-026 SHALL latch comp_sel at index 0 and drive it on sym_comp for every symbol of that block.
REQ-027 SHALL give sof priority: when sof=1, predictors := 0, index := 0, run := 0; a data_valid beat in the same cycle is index 0 of a new block with pred = 0.
REQ-028 SHALL abandon a partially received block on sof mid-block, without emitting EOB or block_done for it; symbols already in the pipeline still emerge.
REQ-029 SHALL ignore comp_sel values 0 or greater than COMP_NUM by using pred index 1, while sym_comp carries the raw value.

Reset
REQ-030 SHALL, while sys_rst_n=0, clear all predictors, index, run, and pipeline registers; all outputs read 0.
REQ-031 SHALL drop all in-flight symbols when reset is asserted; the first beat after release is index 0.

Verification
REQ-032 First Y block with DC=50, AC all zero -> DC symbol size 6, amp 50 at beat+2; EOB with block_done at index-63 beat+2.
REQ-033 Second Y block with DC=45 -> diff -5: size 3, amp 3'b010; third Y block with DC=45 -> size 0, sym_valid=1.
REQ-034 AC value -1 at index 1, 20 zeros, +3 at index 22, rest zero -> (zrl0, run0, size1, amp0); (zrl1, run4, size2, amp 2'b11); EOB.
REQ-035 Y, Cb, Cr blocks each with DC=100, then Y block with DC=100 -> the Cb and Cr DC diffs are 100 (independent predictors); the final Y diff is 0.
REQ-036 Index 63 = 7 after 62 zeros -> one symbol (zrl3, run14, size3, amp7) with block_done; no EOB.
REQ-037 sof asserted at index 30, then a new block with DC=8 and data_valid gaps inserted -> no block_done for the aborted block; DC diff 8; latency is still 2 cycles per beat.

Source files
------------

// File: rtl/rle_encoder.sv
// ----------------------------------------------------------------------------
// rle_encoder
//   JPEG-style run-length symbol generator for zigzag-ordered quantized
//   coefficients. Every 64 data_valid beats form one block. Beat 0 is the DC
//   coefficient and is coded as a difference from that component's predictor.
//   Beats 1..63 are AC coefficients. Zero AC values extend a run. Each nonzero
//   AC value produces one (zrl, run, size, amp) symbol. A zero on beat 63
//   produces the end-of-block symbol.
//   Each symbol appears exactly two cycles after the beat that produced it.
//
// Ports
//   sys_clk     in   clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   sof         in   start of frame: clears predictors, block index and run
//   data_in     in   12-bit signed coefficient
//   data_valid  in   data_in is valid this cycle
//   comp_sel    in   component tag, sampled on beat 0 of a block
//   sym_valid   out  symbol fields are valid
//   sym_is_dc   out  symbol is a DC difference
//   sym_zrl     out  number of 16-zero codes preceding the symbol
//   sym_run     out  zero run modulo 16
//   sym_size    out  magnitude category 0..12
//   sym_amp     out  amplitude bits, right-aligned
//   sym_comp    out  component tag of the producing block
//   block_done  out  marks the last symbol of a block
// ----------------------------------------------------------------------------
module rle_encoder #(
  parameter int COMP_NUM = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                sof,
  input  logic signed [11:0]  data_in,
  input  logic                data_valid,
  input  logic [1:0]          comp_sel,
  output logic                sym_valid,
  output logic                sym_is_dc,
  output logic [1:0]          sym_zrl,
  output logic [3:0]          sym_run,
  output logic [3:0]          sym_size,
  output logic [11:0]         sym_amp,
  output logic [1:0]          sym_comp,
  output logic                block_done
);

  localparam int DATA_W = 12;
  localparam int DIFF_W = DATA_W + 1;

  // Bit length of |v|.
  function automatic logic [3:0] mag_size(input logic signed [DIFF_W-1:0] v);
    logic [DIFF_W-1:0] mag;
    mag      = v[DIFF_W-1] ? $unsigned(-v) : $unsigned(v);
    mag_size = '0;
    for (int i = 0; i < DIFF_W; i++) begin
      if (mag[i]) mag_size = 4'(i + 1);
    end
  endfunction

  // Negative values are sent as the low bits of (v - 1), which is the
  // one's complement of |v|.
  function automatic logic [DATA_W-1:0] amp_bits(input logic signed [DIFF_W-1:0] v,
                                                 input logic [3:0]               size);
    logic [DIFF_W-1:0] raw;
    logic [DIFF_W-1:0] mask;
    raw      = v[DIFF_W-1] ? ($unsigned(v) - DIFF_W'(1)) : $unsigned(v);
    mask     = (DIFF_W'(1) << size) - DIFF_W'(1);
    amp_bits = DATA_W'(raw & mask);
  endfunction

  logic signed [DATA_W-1:0] pred [COMP_NUM+1];
  logic [5:0]               idx_q;
  logic [5:0]               run_q;
  logic [1:0]               comp_q;

  logic [5:0]               idx_eff;
  logic [5:0]               run_eff;
  logic [5:0]               run_nxt;
  logic [1:0]               pidx;
  logic signed [DATA_W-1:0] pred_eff;
  logic signed [DIFF_W-1:0] val_nxt;
  logic                     is_dc;
  logic                     nz;
  logic                     last;
  logic                     emit;
  logic [1:0]               comp_eff;

  // sof takes effect in the same cycle, so a coincident beat starts a new
  // block with a zero predictor.
  always_comb begin
    idx_eff  = sof ? 6'd0 : idx_q;
    run_eff  = sof ? 6'd0 : run_q;
    is_dc    = (idx_eff == 6'd0);
    last     = (idx_eff == 6'd63);
    nz       = (data_in != '0);
    if (comp_sel == 2'd0 || int'(comp_sel) > COMP_NUM) pidx = 2'd1;
    else                                               pidx = comp_sel;
    pred_eff = sof ? '0 : pred[pidx];
    if (is_dc) val_nxt = $signed({data_in[DATA_W-1], data_in}) - $signed({pred_eff[DATA_W-1], pred_eff});
    else       val_nxt = $signed({data_in[DATA_W-1], data_in});
    if (is_dc || nz || last) run_nxt = 6'd0;
    else                     run_nxt = run_eff + 6'd1;
    emit     = data_valid && (is_dc || nz || last);
    comp_eff = is_dc ? comp_sel : comp_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_q  <= '0;
      run_q  <= '0;
      comp_q <= '0;
      for (int i = 0; i <= COMP_NUM; i++) pred[i] <= '0;
    end else begin
      if (sof) begin
        idx_q <= '0;
        run_q <= '0;
        for (int i = 0; i <= COMP_NUM; i++) pred[i] <= '0;
      end
      if (data_valid) begin
        idx_q <= idx_eff + 6'd1;
        run_q <= run_nxt;
        if (is_dc) begin
          pred[pidx] <= data_in;
          comp_q     <= comp_sel;
        end
      end
    end
  end

  // ---- stage p1: symbol decision, value and run captured ----
  logic                     vld_p1;
  logic                     dc_p1;
  logic                     last_p1;
  logic signed [DIFF_W-1:0] val_p1;
  logic [5:0]               run_p1;
  logic [1:0]               comp_p1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p1  <= 1'b0;
      dc_p1   <= 1'b0;
      last_p1 <= 1'b0;
      val_p1  <= '0;
      run_p1  <= '0;
      comp_p1 <= '0;
    end else begin
      vld_p1  <= emit;
      dc_p1   <= is_dc;
      last_p1 <= last;
      val_p1  <= val_nxt;
      // DC and end-of-block symbols carry no run.
      run_p1  <= (is_dc || !nz) ? 6'd0 : run_eff;
      comp_p1 <= comp_eff;
    end
  end

  // ---- stage p2: size/amplitude coding, registered outputs ----
  logic [3:0] size_p1;
  assign size_p1 = mag_size(val_p1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sym_valid  <= 1'b0;
      sym_is_dc  <= 1'b0;
      sym_zrl    <= '0;
      sym_run    <= '0;
      sym_size   <= '0;
      sym_amp    <= '0;
      sym_comp   <= '0;
      block_done <= 1'b0;
    end else begin
      sym_valid  <= vld_p1;
      sym_is_dc  <= vld_p1 && dc_p1;
      sym_zrl    <= vld_p1 ? run_p1[5:4] : 2'd0;
      sym_run    <= vld_p1 ? run_p1[3:0] : 4'd0;
      sym_size   <= vld_p1 ? size_p1 : 4'd0;
      sym_amp    <= vld_p1 ? amp_bits(val_p1, size_p1) : '0;
      sym_comp   <= vld_p1 ? comp_p1 : 2'd0;
      block_done <= vld_p1 && last_p1;
    end
  end

endmodule

// File: tb/tb_rle_encoder.sv
// ----------------------------------------------------------------------------
// tb_rle_encoder
//   Directed and randomized blocks are driven into rle_encoder. A block-level
//   reference model turns each block's coefficient array into the expected
//   symbol list. Each expected symbol is stamped with the time at which it
//   should be observed. A negedge monitor collects the symbols the DUT
//   actually produced, and the two lists are compared after each scenario.
// ----------------------------------------------------------------------------
module tb_rle_encoder;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               sof = 1'b0;
  logic signed [11:0] data_in = '0;
  logic               data_valid = 1'b0;
  logic [1:0]         comp_sel = '0;
  logic               sym_valid;
  logic               sym_is_dc;
  logic [1:0]         sym_zrl;
  logic [3:0]         sym_run;
  logic [3:0]         sym_size;
  logic [11:0]        sym_amp;
  logic [1:0]         sym_comp;
  logic               block_done;

  always #5 sys_clk = ~sys_clk;

  rle_encoder #(.COMP_NUM(3)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sof        (sof),
    .data_in    (data_in),
    .data_valid (data_valid),
    .comp_sel   (comp_sel),
    .sym_valid  (sym_valid),
    .sym_is_dc  (sym_is_dc),
    .sym_zrl    (sym_zrl),
    .sym_run    (sym_run),
    .sym_size   (sym_size),
    .sym_amp    (sym_amp),
    .sym_comp   (sym_comp),
    .block_done (block_done)
  );

  typedef struct packed {
    logic [31:0] t;
    logic        is_dc;
    logic [1:0]  zrl;
    logic [3:0]  run;
    logic [3:0]  size;
    logic [11:0] amp;
    logic [1:0]  comp;
    logic        done;
  } sym_t;

  sym_t               exp_q[$];
  sym_t               obs_q[$];
  sym_t               mon_rec;
  int                 checks = 0;
  int                 errors = 0;
  logic signed [11:0] coef [64];
  logic [31:0]        beat_t [64];
  int                 mpred [4];

  // Monitor: record every cycle that shows a symbol or a block_done.
  always @(negedge sys_clk) begin
    if (sym_valid || block_done) begin
      mon_rec.t     = 32'($time);
      mon_rec.is_dc = sym_is_dc;
      mon_rec.zrl   = sym_zrl;
      mon_rec.run   = sym_run;
      mon_rec.size  = sym_size;
      mon_rec.amp   = sym_amp;
      mon_rec.comp  = sym_comp;
      mon_rec.done  = block_done;
      obs_q.push_back(mon_rec);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input logic signed [11:0] d, input logic [1:0] cs, input logic s,
                      output logic [31:0] t);
    data_in    = d;
    comp_sel   = cs;
    sof        = s;
    data_valid = 1'b1;
    @(posedge sys_clk);
    t = 32'($time);
    #1;
    data_valid = 1'b0;
    sof        = 1'b0;
    data_in    = '0;
    comp_sel   = '0;
  endtask

  function automatic int bitlen(input int a);
    int n = 0;
    int x = a;
    while (x > 0) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  // Expected symbol for value v. The result appears 15 time units after
  // the sampling edge: two clocks later, then seen on the following negedge.
  function automatic sym_t mk(input logic [31:0] tb, input logic dc, input int zeros,
                              input int v, input logic [1:0] comp, input logic done);
    sym_t s;
    int   sz;
    sz      = bitlen(v < 0 ? -v : v);
    s.t     = tb + 32'd15;
    s.is_dc = dc;
    s.zrl   = 2'(zeros / 16);
    s.run   = 4'(zeros % 16);
    s.size  = 4'(sz);
    s.amp   = 12'(v > 0 ? v : v + (1 << sz) - 1);
    s.comp  = comp;
    s.done  = done;
    return s;
  endfunction

  task automatic clear_pred();
    for (int i = 0; i < 4; i++) mpred[i] = 0;
  endtask

  task automatic clear_coef();
    for (int k = 0; k < 64; k++) coef[k] = '0;
  endtask

  // Drive nbeats of coef[] and then append the block's expected symbols.
  task automatic send_block(input logic [1:0] comp, input int nbeats,
                            input logic sof_first, input int gap_max);
    int p;
    int zeros;
    int v;
    for (int k = 0; k < nbeats; k++) begin
      if (k > 0) idle($urandom_range(0, gap_max));
      beat(coef[k], (k == 0) ? comp : 2'($urandom), (k == 0) && sof_first, beat_t[k]);
    end
    if (sof_first) clear_pred();
    p     = (comp == 2'd0) ? 1 : int'(comp);
    zeros = 0;
    for (int k = 0; k < nbeats; k++) begin
      v = int'(coef[k]);
      if (k == 0) begin
        exp_q.push_back(mk(beat_t[k], 1'b1, 0, v - mpred[p], comp, 1'b0));
        mpred[p] = v;
      end else if (v != 0) begin
        exp_q.push_back(mk(beat_t[k], 1'b0, zeros, v, comp, k == 63));
        zeros = 0;
      end else if (k == 63) begin
        exp_q.push_back(mk(beat_t[k], 1'b0, 0, 0, comp, 1'b1));
      end else begin
        zeros++;
      end
    end
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    clear_pred();
  endtask

  task automatic compare_all(input string tag);
    int n;
    idle(4);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_sym%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int   nd;
    int   dens;
    logic [31:0] t0;
    clear_pred();
    clear_coef();

    // Reset: inputs are active but every output must stay low.
    data_valid = 1'b1;
    data_in    = 12'sd77;
    comp_sel   = 2'd1;
    idle(3);
    chk("reset_outputs", {sym_valid, sym_is_dc, sym_zrl, sym_run, sym_size, sym_amp,
                          sym_comp, block_done}, 64'd0);
    data_valid = 1'b0;
    data_in    = '0;
    comp_sel   = '0;
    idle(1);
    sys_rst_n = 1'b1;
    idle(2);
    chk("reset_no_symbols", 64'(obs_q.size()), 64'd0);

    // Y block, DC 50, all AC zero.
    clear_coef();
    coef[0] = 12'sd50;
    send_block(2'd1, 64, 1'b0, 0);
    idle(4);
    chk("s1_dc_size", obs_q[0].size, 4'd6);
    chk("s1_dc_amp", obs_q[0].amp, 12'd50);
    chk("s1_dc_latency", obs_q[0].t - beat_t[0], 32'd15);
    chk("s1_eob", {obs_q[1].done, obs_q[1].is_dc, obs_q[1].size, obs_q[1].run}, {1'b1, 1'b0, 4'd0, 4'd0});
    chk("s1_eob_latency", obs_q[1].t - beat_t[63], 32'd15);
    compare_all("s1");

    // DC 45 twice: diff -5, then diff 0.
    coef[0] = 12'sd45;
    send_block(2'd1, 64, 1'b0, 1);
    idle(4);
    chk("s2_dc_size", obs_q[0].size, 4'd3);
    chk("s2_dc_amp", obs_q[0].amp, 12'b010);
    compare_all("s2a");
    send_block(2'd1, 64, 1'b0, 0);
    idle(4);
    chk("s2_zero_dc", {obs_q[0].is_dc, obs_q[0].size}, {1'b1, 4'd0});
    compare_all("s2b");

    // AC -1 at index 1, +3 at index 22.
    clear_coef();
    coef[0]  = 12'sd45;
    coef[1]  = -12'sd1;
    coef[22] = 12'sd3;
    send_block(2'd1, 64, 1'b0, 1);
    idle(4);
    chk("s3_ac1", {obs_q[1].zrl, obs_q[1].run, obs_q[1].size, obs_q[1].amp}, {2'd0, 4'd0, 4'd1, 12'd0});
    chk("s3_ac22", {obs_q[2].zrl, obs_q[2].run, obs_q[2].size, obs_q[2].amp}, {2'd1, 4'd4, 4'd2, 12'b11});
    compare_all("s3");

    // Independent predictors for Y, Cb and Cr.
    clear_coef();
    coef[0] = 12'sd100;
    send_block(2'd1, 64, 1'b0, 0);
    send_block(2'd2, 64, 1'b0, 0);
    send_block(2'd3, 64, 1'b0, 0);
    send_block(2'd1, 64, 1'b0, 0);
    idle(4);
    chk("s4_cb_dc", {obs_q[2].comp, obs_q[2].size, obs_q[2].amp}, {2'd2, 4'd7, 12'd100});
    chk("s4_cr_dc", {obs_q[4].comp, obs_q[4].size, obs_q[4].amp}, {2'd3, 4'd7, 12'd100});
    chk("s4_y_dc", {obs_q[6].comp, obs_q[6].size}, {2'd1, 4'd0});
    compare_all("s4");

    // Nonzero at index 63 after 62 zeros: no EOB.
    clear_coef();
    coef[0]  = 12'sd100;
    coef[63] = 12'sd7;
    send_block(2'd1, 64, 1'b0, 0);
    idle(4);
    chk("s5_count", 64'(obs_q.size()), 64'd2);
    chk("s5_last", {obs_q[1].zrl, obs_q[1].run, obs_q[1].size, obs_q[1].amp, obs_q[1].done},
        {2'd3, 4'd14, 4'd3, 12'd7, 1'b1});
    compare_all("s5");

    // Block abandoned at index 30 by sof, new block with gaps.
    for (int k = 0; k < 64; k++) coef[k] = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'sd0;
    send_block(2'd2, 30, 1'b0, 2);
    clear_coef();
    coef[0] = 12'sd8;
    coef[5] = -12'sd9;
    send_block(2'd1, 64, 1'b1, 3);
    idle(4);
    nd = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].done) nd++;
    chk("s6_done_count", 64'(nd), 64'd1);
    t0 = beat_t[0] + 32'd15;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].t == t0) chk("s6_new_dc", {obs_q[i].is_dc, obs_q[i].size, obs_q[i].amp}, {1'b1, 4'd4, 12'd8});
    end
    compare_all("s6");

    // Reset with a symbol in flight drops it and restarts at index 0.
    clear_coef();
    beat(-12'sd300, 2'd1, 1'b0, t0);
    sys_rst_n = 1'b0;
    idle(2);
    chk("s7_reset_outputs", {sym_valid, sym_size, sym_amp, block_done}, 64'd0);
    sys_rst_n = 1'b1;
    idle(2);
    clear_pred();
    chk("s7_dropped", 64'(obs_q.size()), 64'd0);
    coef[0] = 12'sd20;
    send_block(2'd1, 64, 1'b0, 1);
    idle(4);
    chk("s7_dc", {obs_q[0].is_dc, obs_q[0].size, obs_q[0].amp}, {1'b1, 4'd5, 12'd20});
    compare_all("s7");

    // Randomized blocks: all components including the out-of-range tag 0.
    for (int b = 0; b < 10; b++) begin
      if ($urandom_range(0, 4) == 0) pulse_sof();
      dens = $urandom_range(2, 24);
      for (int k = 0; k < 64; k++)
        coef[k] = (k == 0 || $urandom_range(0, dens) == 0) ? 12'($urandom) : 12'sd0;
      if (b == 3) coef[63] = -12'sd2048;
      send_block((b == 0) ? 2'd0 : 2'($urandom), 64, 1'($urandom_range(0, 3) == 0), 2);
    end
    compare_all("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
